seg_scan_ctrl: RTL
==================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an N-digit common-cathode 7-segment display.
//  Holds one 4-bit hex value per digit and drives one digit at a time for SCAN_DIV clocks.
//  Decodes each value to segments and accepts digit updates over a valid/ready write port.
//  Commits updates only at slot boundaries so a lit digit never tears mid-slot.
// PARAMETERS
//  NUM_DIGITS  4       number of digits scanned (2..8)
//  SCAN_DIV    25000   clk cycles per digit slot (>= 16, > GUARD_CYC)
//  GUARD_CYC   2       cycles blanked at the start of each slot (anti-ghosting)
// PORTS
//  clk         in   1           clock
//  rst_n       in   1           reset: asynchronous, active-low
//  wr_valid    in   1           write request
//  wr_ready    out  1           write accepted when wr_valid & wr_ready
//  wr_digit    in   3           target digit index
//  wr_value    in   4           hex value 0..F
//  seg_o       out  7           segments {g,f,e,d,c,b,a}, active-high
//  dig_en_o    out  NUM_DIGITS  one-hot digit enable, active-high
//  frame_tick  out  1           1-cycle pulse when scan index wraps to digit 0
// BEHAVIOUR
//  Reset: all digit values 0, scan_cnt=0, scan_idx=0, pending=0.
//   Outputs: seg_o=0, dig_en_o=0, wr_ready=1, frame_tick=0.
//  Scan: scan_cnt counts 0..SCAN_DIV-1. At terminal count, scan_cnt -> 0 and scan_idx increments.
//   scan_idx wraps NUM_DIGITS-1 -> 0. frame_tick pulses in the cycle after that wrap.
//  Outputs are registered, with 1 cycle latency from scan state.
//   While scan_cnt < GUARD_CYC: dig_en_o=0 and seg_o=0.
//   Otherwise: dig_en_o = 1<<scan_idx and seg_o = hex decode of digit[scan_idx].
//  Decode table (hex):
//   0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//   8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
//  Write handshake: one staging entry.
//   wr_ready = !pending.
//   An accepted write loads the staging register, and pending=1 from the next cycle.
//   Commit happens on the terminal-count cycle of the slot: digit[stage_digit] <= stage_value, pending -> 0.
//   wr_ready is high again in the cycle after the commit.
//  Boundary rules:
//   - A write accepted in the terminal-count cycle is not committed in that cycle. It commits at the next boundary.
//   - wr_digit >= NUM_DIGITS: the write is accepted (handshake completes), then discarded at commit with no state change.
//   - A commit to the digit about to be scanned is visible in that digit's new slot, after its guard cycles.
//   - wr_valid may drop without acceptance; no state changes.
//   - Reset mid-slot or mid-pending: everything returns to reset values immediately, and pending data is lost.
// CONFIGURATION
//  SEG_SCAN_DIM_EN defined: adds input port `bright` (in, 4, duty level).
//   Within a slot, after the guard, digits are lit only while scan_cnt[top 4 bits] < bright.
//   bright=15 means always lit. bright=0 means dark.
//   While not lit, seg_o=0 and dig_en_o=0. bright is sampled every cycle.
//  SEG_SCAN_DIM_EN undefined: no `bright` port; the digit is lit for the full slot after the guard.
// STRUCTURE
//  Package seg_pkg:
//   - SEG_BLANK = 7'h00
//   - 16-entry hex-to-segment constant table
//   - function clog2 for the scan_cnt / scan_idx widths
//  Sub-module seg_hex_decoder: combinational, 4-bit value in -> 7-bit segments out, uses the seg_pkg table.
//  Top level holds the scan counter, the digit register file, the staging register, and the output registers.
// TESTING (bench: NUM_DIGITS=4, SCAN_DIV=16, GUARD_CYC=2)
//  1. Reset, then run 64 cycles.
//     -> dig_en_o steps 0001, 0010, 0100, 1000 in 16-cycle slots, each dark for 2 cycles.
//     -> seg_o=3F whenever lit; frame_tick pulses once per 64 cycles.
//  2. Write digit=2 value=A mid-slot 0.
//     -> wr_ready low until the slot-0 terminal count.
//     -> slot-2 seg_o=77; other digits stay 3F.
//  3. Hold wr_valid over 4 writes (d0=1, d1=2, d2=3, d3=4).
//     -> one write accepted per slot.
//     -> after 2 frames, the digits show 06, 5B, 4F, 66.
//  4. Write digit=5 value=F.
//     -> handshake completes; no segment pattern changes across 2 frames.
//  5. Assert rst_n low with a write pending, mid-slot 3.
//     -> outputs 0 immediately and wr_ready=1.
//     -> after release, scanning restarts at digit 0 showing 3F.
//  6. SEG_SCAN_DIM_EN, bright=8.
//     -> each slot is lit for cycles 2..7 and dark for 8..15.
//     -> bright=0 gives dig_en_o=0 for a full frame.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: blank pattern, hex decode table and
// a ceiling-log2 helper used to size the scan counter and digit index.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment order {g,f,e,d,c,b,a}, active-high, indexed by hex value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Ceiling log2, never less than 1 so a vector sized from it is always legal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) begin
        r = i + 1;
      end
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-7-segment decoder driven from the shared table.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[value];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with a one-entry write staging register.
// Define SEG_SCAN_DIM_EN to add the 4-bit `bright` duty-cycle input.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 25000,
  parameter int unsigned GUARD_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_digit,
  input  logic [3:0]            wr_value,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] dig_en_o,
  output logic                  frame_tick
`ifdef SEG_SCAN_DIM_EN
  ,
  input  logic [3:0]            bright
`endif
);

  localparam int unsigned CntW = clog2(SCAN_DIV);
  localparam int unsigned IdxW = clog2(NUM_DIGITS);

  logic [CntW-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]       scan_idx_q, scan_idx_d;
  logic                  term_cnt, last_idx;

  logic [3:0]            digit_q [NUM_DIGITS];
  logic                  pending_q;
  logic [2:0]            stage_digit_q;
  logic [3:0]            stage_value_q;
  logic                  accept, commit;

  logic [6:0]            seg_q, seg_d, cur_seg;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_tick_q;
  logic                  duty_on;

  assign term_cnt = (scan_cnt_q == CntW'(SCAN_DIV - 1));
  assign last_idx = (scan_idx_q == IdxW'(NUM_DIGITS - 1));
  assign accept   = wr_valid && !pending_q;
  // Accept and commit are mutually exclusive, so a write taken on the terminal count
  // naturally waits for the following boundary.
  assign commit   = term_cnt && pending_q;

  always_comb begin
    scan_cnt_d = scan_cnt_q + CntW'(1);
    scan_idx_d = scan_idx_q;
    if (term_cnt) begin
      scan_cnt_d = '0;
      scan_idx_d = last_idx ? '0 : scan_idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= 1'b0;
      stage_digit_q <= '0;
      stage_value_q <= '0;
    end else if (commit) begin
      pending_q <= 1'b0;
    end else if (accept) begin
      pending_q     <= 1'b1;
      stage_digit_q <= wr_digit;
      stage_value_q <= wr_value;
    end
  end

  // Out-of-range digit indices match no entry and are dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (stage_digit_q == 3'(i)) begin
          digit_q[i] <= stage_value_q;
        end
      end
    end
  end

  seg_hex_decoder u_dec (
    .value (digit_q[scan_idx_q]),
    .seg   (cur_seg)
  );

`ifdef SEG_SCAN_DIM_EN
  assign duty_on = (bright == 4'hF) || (scan_cnt_q[CntW-1 -: 4] < bright);
`else
  assign duty_on = 1'b1;
`endif

  always_comb begin
    seg_d    = SEG_BLANK;
    dig_en_d = '0;
    if ((scan_cnt_q >= CntW'(GUARD_CYC)) && duty_on) begin
      seg_d = cur_seg;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_en_d[i] = (scan_idx_q == IdxW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_BLANK;
      dig_en_q     <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_tick_q <= term_cnt && last_idx;
    end
  end

  assign seg_o      = seg_q;
  assign dig_en_o   = dig_en_q;
  assign frame_tick = frame_tick_q;
  assign wr_ready   = !pending_q;

endmodule
